// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges the core's instruction bus (ireq/iresp) and data bus
// (dreq/dresp) onto one single-beat cache/memory bus (creq/cresp).
// Data-first arbitration, with an anti-starvation counter that forces an ibus
// grant after STARVE_LIMIT consecutive dbus grants taken while ibus waited.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ireq  / iresp       fetch request in (held until data_ok) / fetch response out
//   dreq  / dresp       load/store request in (held until data_ok) / response out
//   creq  / cresp       registered single-beat request out / memory response in
//   i_grants, d_grants, stall_cycles   CNT_W-bit performance counters
// Optional feature macro: MEM_ARB_PERF_EN adds the CNT_W parameter and the three
// performance counters; without it the arbitration behaviour is identical.

package mem_bus_arbiter_pkg;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
  typedef enum logic [7:0] {MLEN1 = 8'd0, MLEN2 = 8'd1, MLEN4 = 8'd3, MLEN8 = 8'd7} mlen_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED = 2'd0, AXI_BURST_INCR = 2'd1,
                            AXI_BURST_WRAP = 2'd2} axi_burst_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    msize_t            size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    mlen_t             len;
    axi_burst_t        burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_ARB_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
`ifdef MEM_ARB_PERF_EN
  , output logic [CNT_W-1:0] i_grants
  , output logic [CNT_W-1:0] d_grants
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  localparam int unsigned        STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [1:0]          state, state_n;
  cbus_req_t           creq_n;
  logic [STARVE_W-1:0] starve_cnt, starve_n;
  logic                done_c;

  // State, latched request (which is creq itself) and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      creq       <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      creq       <= creq_n;
      starve_cnt <= starve_n;
    end
  end

  // Arbitration, request latching and completion detection.
  always_comb begin
    state_n  = state;
    creq_n   = creq;
    starve_n = starve_cnt;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!ireq.valid) starve_n = '0;
        // Data wins unless ibus has already waited through STARVE_LIMIT grants.
        if (dreq.valid && !(ireq.valid && starve_cnt == STARVE_MAX)) begin
          state_n         = DATA;
          creq_n.valid    = 1'b1;
          creq_n.is_write = |dreq.strobe;
          creq_n.size     = dreq.size;
          creq_n.addr     = dreq.addr;
          creq_n.strobe   = dreq.strobe;
          creq_n.data     = dreq.data;
          creq_n.len      = MLEN1;
          creq_n.burst    = AXI_BURST_FIXED;
          if (ireq.valid && starve_cnt != STARVE_MAX)
            starve_n = starve_cnt + STARVE_W'(1);
        end else if (ireq.valid) begin
          state_n         = FETCH;
          creq_n.valid    = 1'b1;
          creq_n.is_write = 1'b0;
          creq_n.size     = MSIZE4;
          creq_n.addr     = ireq.addr;
          creq_n.strobe   = '0;
          creq_n.data     = '0;
          creq_n.len      = MLEN1;
          creq_n.burst    = AXI_BURST_FIXED;
          starve_n        = '0;
        end
      end
      FETCH, DATA: begin
        if (cresp.ready && cresp.last) begin
          done_c  = 1'b1;
          state_n = IDLE;
          creq_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        creq_n  = '0;
      end
    endcase
  end

  // Completion pulse to the granted port; dropped if that requester gave up.
  always_comb begin
    iresp = '0;
    dresp = '0;
    if (done_c && state == FETCH && ireq.valid) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = cresp.data;
    end
    if (done_c && state == DATA && dreq.valid) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic grant_i_c, grant_d_c;
  assign grant_i_c = (state == IDLE) && (state_n == FETCH);
  assign grant_d_c = (state == IDLE) && (state_n == DATA);

  // Free-running performance counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_grants     <= '0;
      d_grants     <= '0;
      stall_cycles <= '0;
    end else begin
      if (grant_i_c) i_grants <= i_grants + CNT_W'(1);
      if (grant_d_c) d_grants <= d_grants + CNT_W'(1);
      if (creq.valid && !cresp.ready) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule
